// File: rtl/relay_scan_sequencer.sv
// Relay lead-config scan sequencer. Each config goes through break-before-make,
// a settle period and one acquisition handshake, either once or continuously.
module relay_scan_sequencer #(
  parameter int unsigned BREAK_CYCLES   = 16,
  parameter int unsigned SETTLE_CYCLES  = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned TMR_W          = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       continuous_i,
  input  logic [3:0] first_cfg_i,
  input  logic [3:0] last_cfg_i,
  input  logic       acq_done_i,
  output logic [3:0] count_o,
  output logic       acq_req_o,
  output logic       busy_o,
  output logic       scan_done_o,
  output logic       timeout_err_o,
  output logic       cfg_err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BREAK,
    S_SETTLE,
    S_ACQ,
    S_NEXT
  } state_e;

  localparam logic [TMR_W-1:0] BREAK_LAST   = TMR_W'(BREAK_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST  = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_MAX      = {TMR_W{1'b1}};

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [3:0]       curCfg_q, curCfg_d;
  logic [3:0]       firstCfg_q, firstCfg_d;
  logic [3:0]       lastCfg_q, lastCfg_d;
  logic             contMode_q, contMode_d;
  logic [3:0]       count_q, count_d;
  logic             acqReq_q, acqReq_d;
  logic             busy_q, busy_d;
  logic             scanDone_q, scanDone_d;
  logic             timeoutErr_q, timeoutErr_d;
  logic             cfgErr_q, cfgErr_d;
  logic             rangeOk;

  assign rangeOk = (first_cfg_i != 4'd0) && (last_cfg_i <= 4'd13) &&
                   (first_cfg_i <= last_cfg_i);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      curCfg_q     <= '0;
      firstCfg_q   <= '0;
      lastCfg_q    <= '0;
      contMode_q   <= 1'b0;
      count_q      <= '0;
      acqReq_q     <= 1'b0;
      busy_q       <= 1'b0;
      scanDone_q   <= 1'b0;
      timeoutErr_q <= 1'b0;
      cfgErr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      curCfg_q     <= curCfg_d;
      firstCfg_q   <= firstCfg_d;
      lastCfg_q    <= lastCfg_d;
      contMode_q   <= contMode_d;
      count_q      <= count_d;
      acqReq_q     <= acqReq_d;
      busy_q       <= busy_d;
      scanDone_q   <= scanDone_d;
      timeoutErr_q <= timeoutErr_d;
      cfgErr_q     <= cfgErr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    curCfg_d     = curCfg_q;
    firstCfg_d   = firstCfg_q;
    lastCfg_d    = lastCfg_q;
    contMode_d   = contMode_q;
    scanDone_d   = 1'b0;
    timeoutErr_d = 1'b0;
    cfgErr_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i && !stop_i) begin
          if (rangeOk) begin
            firstCfg_d = first_cfg_i;
            lastCfg_d  = last_cfg_i;
            contMode_d = continuous_i;
            curCfg_d   = first_cfg_i;
            state_d    = S_BREAK;
          end else begin
            cfgErr_d = 1'b1;
          end
        end
      end
      S_BREAK: begin
        if (timer_q >= BREAK_LAST) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (timer_q >= SETTLE_LAST) state_d = S_ACQ;
      end
      S_ACQ: begin
        // A done arriving on the expiry cycle wins over the timeout.
        if (acq_done_i) begin
          state_d = S_NEXT;
        end else if (timer_q >= TIMEOUT_LAST) begin
          state_d      = S_NEXT;
          timeoutErr_d = 1'b1;
        end
      end
      S_NEXT: begin
        if (curCfg_q < lastCfg_q) begin
          curCfg_d = curCfg_q + 4'd1;
          state_d  = S_BREAK;
        end else if (contMode_q) begin
          curCfg_d = firstCfg_q;
          state_d  = S_BREAK;
        end else begin
          scanDone_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (stop_i && (state_q != S_IDLE)) begin
      state_d      = S_IDLE;
      scanDone_d   = 1'b0;
      timeoutErr_d = 1'b0;
    end

    if (state_d != state_q) begin
      timer_d = '0;
    end else if (timer_q == TMR_MAX) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + TMR_W'(1);
    end

    // Outputs are registered from the next state so they align with it.
    count_d  = ((state_d == S_SETTLE) || (state_d == S_ACQ) || (state_d == S_NEXT))
               ? curCfg_d : 4'd0;
    acqReq_d = (state_d == S_ACQ);
    busy_d   = (state_d != S_IDLE);
  end

  assign count_o       = count_q;
  assign acq_req_o     = acqReq_q;
  assign busy_o        = busy_q;
  assign scan_done_o   = scanDone_q;
  assign timeout_err_o = timeoutErr_q;
  assign cfg_err_o     = cfgErr_q;

endmodule

// File: tb/tb_relay_scan_sequencer.sv
// Bench for relay_scan_sequencer: a slot-timing model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_relay_scan_sequencer;

  localparam int B  = 2;
  localparam int S  = 3;
  localparam int TO = 5;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       start_i, stop_i, continuous_i, acq_done_i;
  logic [3:0] first_cfg_i, last_cfg_i;
  logic [3:0] count_o;
  logic       acq_req_o, busy_o, scan_done_o, timeout_err_o, cfg_err_o;

  int checks = 0;
  int errors = 0;

  relay_scan_sequencer #(
    .BREAK_CYCLES(B), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(TO), .TMR_W(8)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .stop_i(stop_i),
    .continuous_i(continuous_i), .first_cfg_i(first_cfg_i), .last_cfg_i(last_cfg_i),
    .acq_done_i(acq_done_i), .count_o(count_o), .acq_req_o(acq_req_o),
    .busy_o(busy_o), .scan_done_o(scan_done_o), .timeout_err_o(timeout_err_o),
    .cfg_err_o(cfg_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Model: a scan is a series of slots; slot cycle t<B is the break,
  // B..B+S-1 settle, then acquisition until acqEnd, which is the single hand-off cycle.
  bit modelValid = 0;
  bit mActive = 0, mCont = 0;
  int mCur = 0, mFirst = 0, mLast = 0, t = 0, acqEnd = -1;
  bit eScanDone = 0, eTimeout = 0, eCfgErr = 0;

  always @(posedge clk_i) begin
    eScanDone = 0; eTimeout = 0; eCfgErr = 0;
    if (!rst_n_i) begin
      mActive = 0; mCur = 0; t = 0; acqEnd = -1; modelValid = 1;
    end else if (!mActive) begin
      if (start_i && !stop_i) begin
        if (first_cfg_i >= 1 && last_cfg_i <= 13 && first_cfg_i <= last_cfg_i) begin
          mActive = 1; mFirst = first_cfg_i; mLast = last_cfg_i; mCont = continuous_i;
          mCur = first_cfg_i; t = 0; acqEnd = -1;
        end else begin
          eCfgErr = 1;
        end
      end
    end else if (stop_i) begin
      mActive = 0;
    end else if (acqEnd < 0 && t >= B + S) begin
      if (acq_done_i) acqEnd = t + 1;
      else if (t - (B + S) == TO - 1) begin acqEnd = t + 1; eTimeout = 1; end
      t++;
    end else if (t == acqEnd) begin
      if (mCur < mLast) begin mCur++; t = 0; acqEnd = -1; end
      else if (mCont) begin mCur = mFirst; t = 0; acqEnd = -1; end
      else begin mActive = 0; eScanDone = 1; end
    end else begin
      t++;
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Observation record used by the directed scenarios.
  int seqQ[$];
  int prevCount = 0;
  int acqHigh = 0, nScanDone = 0, nTimeout = 0, nCfgErr = 0;

  always @(negedge clk_i) begin
    if (modelValid) begin
      checkOutput("count", count_o, (!mActive || t < B) ? 0 : mCur);
      checkOutput("acq_req", acq_req_o, (mActive && acqEnd < 0 && t >= B + S) ? 1 : 0);
      checkOutput("busy", busy_o, mActive);
      checkOutput("scan_done", scan_done_o, eScanDone);
      checkOutput("timeout_err", timeout_err_o, eTimeout);
      checkOutput("cfg_err", cfg_err_o, eCfgErr);
      if (prevCount != 0 && count_o != 0 && count_o != 4'(prevCount))
        checkOutput("breakBeforeMake", count_o, 0);
      if (count_o != 0 && prevCount == 0) seqQ.push_back(count_o);
      prevCount = count_o;
      acqHigh   += acq_req_o;
      nScanDone += scan_done_o;
      nTimeout  += timeout_err_o;
      nCfgErr   += cfg_err_o;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic applyStimulus(input logic st, input logic sp, input logic cont,
                               input logic [3:0] f, input logic [3:0] l, input logic done);
    start_i = st; stop_i = sp; continuous_i = cont;
    first_cfg_i = f; last_cfg_i = l; acq_done_i = done;
    tick(1);
    start_i = 0; stop_i = 0; acq_done_i = 0;
  endtask

  task automatic clearObs();
    seqQ.delete();
    acqHigh = 0; nScanDone = 0; nTimeout = 0; nCfgErr = 0;
  endtask

  // what: 0 = acq_req high, 1 = busy low, 2 = count equals val
  task automatic waitUntil(input int what, input int val, input string name);
    bit hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      case (what)
        0: hit = acq_req_o;
        1: hit = !busy_o;
        default: hit = (count_o == 4'(val));
      endcase
      if (!hit) tick(1);
    end
    if (!hit) checkOutput({name, "_timeout"}, 0, 1);
  endtask

  task automatic checkSeq(input string name, input int n, input int a, input int b, input int c);
    int ex[3];
    ex = '{a, b, c};
    checkOutput({name, "_len"}, seqQ.size(), n);
    for (int i = 0; i < n && i < seqQ.size(); i++)
      checkOutput(name, seqQ[i], ex[i]);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n_i = 0; start_i = 0; stop_i = 0; continuous_i = 0;
    first_cfg_i = 0; last_cfg_i = 0; acq_done_i = 0;
    tick(3);
    rst_n_i = 1;
    checkOutput("rst_count", count_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_acq", acq_req_o, 0);

    // Reset mid-ACQ, also pinning start latency.
    applyStimulus(1, 0, 0, 4'd1, 4'd1, 0);
    checkOutput("lat_busy", busy_o, 1);
    checkOutput("lat_count0", count_o, 0);
    tick(2);
    checkOutput("lat_count1", count_o, 1);
    tick(3);
    checkOutput("lat_acq", acq_req_o, 1);
    rst_n_i = 0;
    tick(1);
    rst_n_i = 1;
    checkOutput("rstAcq_count", count_o, 0);
    checkOutput("rstAcq_acq", acq_req_o, 0);
    checkOutput("rstAcq_busy", busy_o, 0);
    tick(2);

    // One pass 1..3.
    clearObs();
    applyStimulus(1, 0, 0, 4'd1, 4'd3, 0);
    for (int k = 0; k < 3; k++) begin
      waitUntil(0, 0, "pass_acq");
      tick(1);
      applyStimulus(0, 0, 0, 4'd1, 4'd3, 1);
    end
    waitUntil(1, 0, "pass_idle");
    tick(1);
    checkSeq("pass_seq", 3, 1, 2, 3);
    checkOutput("pass_scanDone", nScanDone, 1);
    checkOutput("pass_busy", busy_o, 0);

    // Continuous wrap 12..13, then stop in SETTLE.
    clearObs();
    applyStimulus(1, 0, 1, 4'd12, 4'd13, 0);
    for (int k = 0; k < 2; k++) begin
      waitUntil(0, 0, "cont_acq");
      tick(1);
      applyStimulus(0, 0, 1, 4'd12, 4'd13, 1);
    end
    waitUntil(2, 12, "cont_wrap");
    applyStimulus(0, 1, 1, 4'd12, 4'd13, 0);
    checkOutput("stop_count", count_o, 0);
    checkOutput("stop_busy", busy_o, 0);
    tick(1);
    checkSeq("cont_seq", 3, 12, 13, 12);
    checkOutput("cont_scanDone", nScanDone, 0);

    // Timeout on a single config.
    clearObs();
    applyStimulus(1, 0, 0, 4'd5, 4'd5, 0);
    waitUntil(1, 0, "to_idle");
    tick(1);
    checkOutput("to_acqHigh", acqHigh, 5);
    checkOutput("to_timeoutErr", nTimeout, 1);
    checkOutput("to_scanDone", nScanDone, 1);

    // Invalid ranges.
    clearObs();
    applyStimulus(1, 0, 0, 4'd4, 4'd2, 0);
    checkOutput("bad1_cfgErr", cfg_err_o, 1);
    checkOutput("bad1_busy", busy_o, 0);
    applyStimulus(1, 0, 0, 4'd0, 4'd5, 0);
    checkOutput("bad2_cfgErr", cfg_err_o, 1);
    applyStimulus(1, 0, 0, 4'd1, 4'd14, 0);
    checkOutput("bad3_cfgErr", cfg_err_o, 1);
    checkOutput("bad3_count", count_o, 0);
    tick(1);
    checkOutput("bad_cfgErrCount", nCfgErr, 3);

    // Collisions.
    clearObs();
    applyStimulus(1, 1, 0, 4'd7, 4'd7, 0);
    checkOutput("startStop_busy", busy_o, 0);
    checkOutput("startStop_cfgErr", cfg_err_o, 0);
    applyStimulus(1, 0, 0, 4'd7, 4'd7, 0);
    tick(2);
    applyStimulus(1, 0, 1, 4'd2, 4'd9, 1);
    checkOutput("stray_count", count_o, 7);
    waitUntil(0, 0, "col_acq");
    tick(TO - 1);
    applyStimulus(0, 0, 1, 4'd2, 4'd9, 1);
    waitUntil(1, 0, "col_idle");
    tick(1);
    checkOutput("col_timeoutErr", nTimeout, 0);
    checkOutput("col_scanDone", nScanDone, 1);
    checkSeq("col_seq", 1, 7, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
